fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  PC generator plus IF/ID pipeline register in front of the 4096x16 instruction memory.
//  Drives the memory word address PCAdd_pc and captures the asynchronous-read M_instruction.
//  Hands the instruction and its PC to decode, and handles stall, branch redirect/flush and HALT.
// PARAMETERS
//  PC_W       12        PC / memory address width
//  INSTR_W    16        instruction width
//  RESET_PC   12'h000   PC value loaded on reset
//  NOP_INSTR  16'h0000  bubble word written into IF/ID on flush or halt
//  HALT_OP    4'b1111   opcode (instr[15:12]) that stops fetch
//  CNT_W      16        perf counter width (FETCH_PERF_EN only)
// PORTS
//  clk               in   1        rising-edge clock
//  reset             in   1        asynchronous, active-high reset
//  stall             in   1        hazard unit: hold PC and IF/ID
//  branch_taken      in   1        redirect request from execute
//  branch_target     in   PC_W     absolute redirect address
//  M_instruction     in   INSTR_W  instruction memory read data (combinational)
//  PCAdd_pc          out  PC_W     instruction memory address (= PC register)
//  IFID_instruction  out  INSTR_W  instruction to decode
//  IFID_pc           out  PC_W     address of IFID_instruction
//  IFID_valid        out  1        IF/ID holds a real instruction
//  fetch_halted      out  1        FSM in HALTED
//  perf_fetch_cnt    out  CNT_W    instructions latched into IF/ID
//  perf_stall_cnt    out  CNT_W    cycles with stall=1 in RUN
// BEHAVIOUR
//  - Reset (async, immediate):
//    - PC=RESET_PC, IFID_instruction=NOP_INSTR, IFID_pc=0, IFID_valid=0.
//    - FSM=RUN, fetch_halted=0, counters=0.
//  - PCAdd_pc is the PC register. Memory read is combinational.
//    The word at PC is latched into IF/ID on the next edge (1-cycle fetch latency).
//  - FSM states: RUN, HALTED. fetch_halted = (state==HALTED), registered.
//  - Per-edge priority: branch_taken > stall > normal.
//    - branch_taken (any state, overrides stall):
//      - PC<=branch_target; IFID_instruction<=NOP_INSTR; IFID_valid<=0; IFID_pc<=branch_target.
//      - FSM<=RUN.
//    - stall, RUN: PC, IF/ID and FSM hold. perf_stall_cnt+1.
//    - normal, RUN: IFID_instruction<=M_instruction; IFID_pc<=PC; IFID_valid<=1; perf_fetch_cnt+1.
//      - If M_instruction[15:12]!=HALT_OP: PC<=PC+1, modulo 2^PC_W (12'hFFF -> 12'h000).
//      - If M_instruction[15:12]==HALT_OP: PC holds, FSM<=HALTED. The HALT word itself passes to decode with valid=1.
//    - HALTED (no branch): PC holds. IFID_instruction<=NOP_INSTR; IFID_valid<=0. stall is ignored.
//  - A HALT word present while stall=1 is not latched, so no transition occurs.
//  - All arithmetic is unsigned, width PC_W; no carry out.
//  - Reset asserted mid-cycle overrides everything; fetch restarts at RESET_PC after deassertion.
// CONFIGURATION
//  - FETCH_PERF_EN defined:
//    - perf_fetch_cnt / perf_stall_cnt count as above.
//    - Both wrap at 2^CNT_W; cleared only by reset.
//  - FETCH_PERF_EN undefined:
//    - Counter registers are not built; both ports are tied to 0.
//    - All other behaviour is identical.
// TESTING
//  - Mem[0..2]=6142,6243,2324; release reset -> IFID (pc,instr) = (0,6142),(1,6243),(2,2324) on edges 1-3; valid=1 from edge 1.
//  - stall=1 for 2 cycles at PC=3 -> PCAdd_pc stays 3, IFID holds (2,2324); resumes at pc 3; with FETCH_PERF_EN perf_stall_cnt=2.
//  - stall=1 and branch_taken=1 (target 12'h010) on the same edge -> next: PCAdd_pc=010, IFID_valid=0, IFID_instruction=0000; then IFID (010, mem[010]).
//  - Branch to 12'hFFF -> IFID_pc FFF then 000; PCAdd_pc wraps to 000.
//  - Mem[5]=16'hF000 -> IFID (5,F000) valid=1, then valid=0 and fetch_halted=1 with PCAdd_pc=5; branch to 0 -> fetch_halted=0 and fetch resumes at 0.
//  - Assert reset between edges after 10 fetches -> outputs clear immediately, without an edge; before that perf_fetch_cnt=10 with macro, 0 without.

Source files
------------

// File: rtl/fetch_stage.sv
// PC generator and IF/ID pipeline register with stall, branch redirect/flush and HALT handling.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter int unsigned         PC_W      = 12,
    parameter int unsigned         INSTR_W   = 16,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
    parameter logic [3:0]          HALT_OP   = 4'b1111,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] M_instruction,
    output logic [PC_W-1:0]    PCAdd_pc,
    output logic [INSTR_W-1:0] IFID_instruction,
    output logic [PC_W-1:0]    IFID_pc,
    output logic               IFID_valid,
    output logic               fetch_halted,
    output logic [CNT_W-1:0]   perf_fetch_cnt,
    output logic [CNT_W-1:0]   perf_stall_cnt
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               halted_q, halted_d;
    logic               fetch_en;
    logic               stall_en;
    logic               is_halt;

    assign is_halt  = (M_instruction[INSTR_W-1 -: 4] == HALT_OP);
    assign fetch_en = !branch_taken && !stall && (state_q == StRun);
    assign stall_en = !branch_taken && stall && (state_q == StRun);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (branch_taken) begin
            // Redirect flushes the word fetched from the wrong path.
            pc_d         = branch_target;
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = branch_target;
            ifid_valid_d = 1'b0;
            state_d      = StRun;
        end else if (state_q == StHalted) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (fetch_en) begin
            ifid_instr_d = M_instruction;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            if (is_halt) begin
                state_d = StHalted;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
        halted_d = (state_d == StHalted);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign PCAdd_pc         = pc_q;
    assign IFID_instruction = ifid_instr_q;
    assign IFID_pc          = ifid_pc_q;
    assign IFID_valid       = ifid_valid_q;
    assign fetch_halted     = halted_q;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_en) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        if (stall_en) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    logic unused_perf;
    assign unused_perf    = fetch_en ^ stall_en;
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch order, stall, branch flush, PC wrap, HALT and async reset.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic [15:0] M_instruction;
    logic [11:0] PCAdd_pc;
    logic [15:0] IFID_instruction;
    logic [11:0] IFID_pc;
    logic        IFID_valid;
    logic        fetch_halted;
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;

    logic [15:0] mem [4096];

    int compared = 0;
    int mismatched = 0;

`ifdef FETCH_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .M_instruction    (M_instruction),
        .PCAdd_pc         (PCAdd_pc),
        .IFID_instruction (IFID_instruction),
        .IFID_pc          (IFID_pc),
        .IFID_valid       (IFID_valid),
        .fetch_halted     (fetch_halted),
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    assign M_instruction = mem[PCAdd_pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [11:0] pc, input logic [15:0] instr,
                              input logic valid, input logic [11:0] next_pc);
        check({tag, ".ifid_pc"}, 32'(IFID_pc), 32'(pc));
        check({tag, ".ifid_instr"}, 32'(IFID_instruction), 32'(instr));
        check({tag, ".ifid_valid"}, 32'(IFID_valid), 32'(valid));
        check({tag, ".pcadd"}, 32'(PCAdd_pc), 32'(next_pc));
    endtask

    // Advance one rising edge and sample at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'h6142;
        mem[1] = 16'h6243;
        mem[2] = 16'h2324;

        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 12'h000;
        #1;
        check_ifid("reset", 12'h000, 16'h0000, 1'b0, 12'h000);
        check("reset.halted", 32'(fetch_halted), 32'd0);
        check("reset.fcnt", 32'(perf_fetch_cnt), 32'd0);
        check("reset.scnt", 32'(perf_stall_cnt), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        step(); check_ifid("e1", 12'h000, 16'h6142, 1'b1, 12'h001);
        step(); check_ifid("e2", 12'h001, 16'h6243, 1'b1, 12'h002);
        step(); check_ifid("e3", 12'h002, 16'h2324, 1'b1, 12'h003);

        stall = 1'b1;
        step(); check_ifid("stall1", 12'h002, 16'h2324, 1'b1, 12'h003);
        step(); check_ifid("stall2", 12'h002, 16'h2324, 1'b1, 12'h003);
        stall = 1'b0;
        step(); check_ifid("resume", 12'h003, 16'h1003, 1'b1, 12'h004);
        check("resume.scnt", 32'(perf_stall_cnt), PerfOn ? 32'd2 : 32'd0);

        // Branch beats stall on the same edge.
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 12'h010;
        step(); check_ifid("br010", 12'h010, 16'h0000, 1'b0, 12'h010);
        stall = 1'b0;
        branch_taken = 1'b0;
        step(); check_ifid("br010.f", 12'h010, 16'h1010, 1'b1, 12'h011);

        branch_taken = 1'b1;
        branch_target = 12'hFFF;
        step(); check_ifid("brFFF", 12'hFFF, 16'h0000, 1'b0, 12'hFFF);
        branch_taken = 1'b0;
        step(); check_ifid("wrap", 12'hFFF, 16'h1FFF, 1'b1, 12'h000);
        step(); check_ifid("wrap.f", 12'h000, 16'h6142, 1'b1, 12'h001);

        mem[5] = 16'hF000;
        branch_taken = 1'b1;
        branch_target = 12'h005;
        step(); check_ifid("br005", 12'h005, 16'h0000, 1'b0, 12'h005);
        branch_taken = 1'b0;
        step(); check_ifid("halt.word", 12'h005, 16'hF000, 1'b1, 12'h005);
        step(); check_ifid("halted", 12'h005, 16'h0000, 1'b0, 12'h005);
        check("halted.flag", 32'(fetch_halted), 32'd1);
        stall = 1'b1;
        step(); check_ifid("halted.stall", 12'h005, 16'h0000, 1'b0, 12'h005);
        check("halted.stall.flag", 32'(fetch_halted), 32'd1);
        check("halted.scnt", 32'(perf_stall_cnt), PerfOn ? 32'd2 : 32'd0);

        branch_taken = 1'b1;
        branch_target = 12'h000;
        step(); check_ifid("unhalt", 12'h000, 16'h0000, 1'b0, 12'h000);
        check("unhalt.flag", 32'(fetch_halted), 32'd0);
        stall = 1'b0;
        branch_taken = 1'b0;
        step(); check_ifid("unhalt.f0", 12'h000, 16'h6142, 1'b1, 12'h001);
        step(); check_ifid("unhalt.f1", 12'h001, 16'h6243, 1'b1, 12'h002);
        check("pre_reset.fcnt", 32'(perf_fetch_cnt), PerfOn ? 32'd10 : 32'd0);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check_ifid("async_rst", 12'h000, 16'h0000, 1'b0, 12'h000);
        check("async_rst.fcnt", 32'(perf_fetch_cnt), 32'd0);
        check("async_rst.scnt", 32'(perf_stall_cnt), 32'd0);
        check("async_rst.flag", 32'(fetch_halted), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        step(); check_ifid("restart", 12'h000, 16'h6142, 1'b1, 12'h001);
        check("restart.fcnt", 32'(perf_fetch_cnt), PerfOn ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
